// File: rtl/param_fifo.sv
// param_fifo -- single-clock synchronous FIFO with occupancy flags and
// sticky error flags.
//
// Ports:
//   clk          in   rising-edge clock for all state
//   resetN       in   synchronous, active-low reset
//   write        in   push request (dataIn is stored when accepted)
//   read         in   pop request (dataOut loaded when accepted)
//   dataIn       in   WIDTH-bit word to push
//   clearErr     in   clears overflow/underflow (wins over a same-cycle set)
//   dataOut      out  registered word from the most recent accepted pop
//   count        out  current occupancy, 0..DEPTH
//   full/empty   out  count == DEPTH / count == 0
//   almostFull   out  count >= AF_LEVEL
//   almostEmpty  out  count <= AE_LEVEL
//   overflow     out  sticky: a push was rejected
//   underflow    out  sticky: a pop was rejected
module param_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       write,
    input  logic                       read,
    input  logic [WIDTH-1:0]           dataIn,
    input  logic                       clearErr,
    output logic [WIDTH-1:0]           dataOut,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       almostFull,
    output logic                       almostEmpty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

    // Storage array without reset so it maps onto block/distributed RAM;
    // the read port is registered through data_out_reg.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [WIDTH-1:0] data_out_reg;
    logic             overflow_reg, overflow_next;
    logic             underflow_reg, underflow_next;

    logic full_int;
    logic empty_int;
    logic push_ok;
    logic pop_ok;

    assign full_int  = (count_reg == DEPTH_CNT);
    assign empty_int = (count_reg == '0);

    // A push into a full FIFO is still accepted when a pop frees the head
    // slot in the same cycle. A pop from an empty FIFO is never accepted,
    // so a simultaneous push does not fall through to dataOut.
    assign push_ok = write && (!full_int || read);
    assign pop_ok  = read && !empty_int;

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;

        // DEPTH is a power of two, so natural pointer overflow wraps to 0.
        if (push_ok) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end

        if (push_ok && !pop_ok) begin
            count_next = count_reg + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_next = count_reg - CNT_W'(1);
        end

        if (clearErr) begin
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end else begin
            if (write && full_int && !read) begin
                overflow_next = 1'b1;
            end
            if (read && empty_int) begin
                underflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            data_out_reg  <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
            // When full with push and pop together, wr_ptr == rd_ptr: the
            // non-blocking read below still returns the old head word.
            if (pop_ok) begin
                data_out_reg <= mem[rd_ptr_reg];
            end
        end
    end

    // Memory write is gated by reset so pushes during reset are discarded.
    always_ff @(posedge clk) begin
        if (resetN && push_ok) begin
            mem[wr_ptr_reg] <= dataIn;
        end
    end

    assign dataOut     = data_out_reg;
    assign count       = count_reg;
    assign full        = full_int;
    assign empty       = empty_int;
    assign almostFull  = (count_reg >= AF_CNT);
    assign almostEmpty = (count_reg <= AE_CNT);
    assign overflow    = overflow_reg;
    assign underflow   = underflow_reg;

endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo -- directed plus short random test of param_fifo
// (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1). A reference queue holds the
// words the bench has pushed; each accepted pop removes the front entry,
// which becomes the expected dataOut after the edge.
module tb_param_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic             clk;
    logic             resetN;
    logic             write;
    logic             read;
    logic [WIDTH-1:0] dataIn;
    logic             clearErr;
    logic [WIDTH-1:0] dataOut;
    logic [2:0]       count;
    logic             full;
    logic             empty;
    logic             almostFull;
    logic             almostEmpty;
    logic             overflow;
    logic             underflow;

    param_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk(clk), .resetN(resetN), .write(write), .read(read),
        .dataIn(dataIn), .clearErr(clearErr), .dataOut(dataOut),
        .count(count), .full(full), .empty(empty),
        .almostFull(almostFull), .almostEmpty(almostEmpty),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic [WIDTH-1:0] sb_q[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_ovf;
    logic             m_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, update the reference, wait for the
    // edge, then compare every output against the reference.
    task automatic step(input logic rn, input logic w, input logic r,
                        input logic [WIDTH-1:0] d, input logic c);
        int  sz;
        bit  m_full, m_empty, pop_ok, push_ok;
        resetN   = rn;
        write    = w;
        read     = r;
        dataIn   = d;
        clearErr = c;
        if (!rn) begin
            sb_q.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            sz      = sb_q.size();
            m_full  = (sz == DEPTH);
            m_empty = (sz == 0);
            pop_ok  = r && !m_empty;
            push_ok = w && (!m_full || r);
            if (pop_ok)  m_dout = sb_q.pop_front();
            if (push_ok) sb_q.push_back(d);
            if (c) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end else begin
                if (w && m_full && !r) m_ovf = 1'b1;
                if (r && m_empty)      m_unf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        sz = sb_q.size();
        $display("t=%0t rn=%0b w=%0b r=%0b din=%0d clr=%0b -> dout=%0d cnt=%0d full=%0b empty=%0b af=%0b ae=%0b ovf=%0b unf=%0b",
                 $time, rn, w, r, d, c, dataOut, count, full, empty,
                 almostFull, almostEmpty, overflow, underflow);
        chk("dataOut",     32'(dataOut),     32'(m_dout));
        chk("count",       32'(count),       32'(sz));
        chk("full",        32'(full),        32'(sz == DEPTH));
        chk("empty",       32'(empty),       32'(sz == 0));
        chk("almostFull",  32'(almostFull),  32'(sz >= AF));
        chk("almostEmpty", 32'(almostEmpty), 32'(sz <= AE));
        chk("overflow",    32'(overflow),    32'(m_ovf));
        chk("underflow",   32'(underflow),   32'(m_unf));
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        step(1'b1, 1'b1, 1'b0, d, 1'b0);
    endtask

    task automatic pop();
        step(1'b1, 1'b0, 1'b1, '0, 1'b0);
    endtask

    task automatic idle_clear();
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    endtask

    logic [WIDTH-1:0] exp_list [6];

    initial begin
        resetN = 1'b0; write = 1'b0; read = 1'b0; dataIn = '0; clearErr = 1'b0;
        m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;

        // Reset state
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'hAA, 1'b1);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_dout",  32'(dataOut), 32'd0);

        // Fill with flag thresholds
        push(8'd1);
        chk("s1_cnt", 32'(count), 32'd1);
        chk("s1_ae",  32'(almostEmpty), 32'd1);
        push(8'd3);
        chk("s2_ae",  32'(almostEmpty), 32'd0);
        push(8'd2);
        chk("s3_af",  32'(almostFull), 32'd1);
        chk("s3_cnt", 32'(count), 32'd3);
        push(8'd7);
        chk("s4_full", 32'(full), 32'd1);
        push(8'd9);
        chk("s5_ovf", 32'(overflow), 32'd1);
        chk("s5_cnt", 32'(count), 32'd4);
        pop(); chk("pop1", 32'(dataOut), 32'd1);
        pop(); chk("pop3", 32'(dataOut), 32'd3);
        pop(); chk("pop2", 32'(dataOut), 32'd2);
        pop(); chk("pop7", 32'(dataOut), 32'd7);
        chk("drained_empty", 32'(empty), 32'd1);
        pop(); chk("empty_pop_unf", 32'(underflow), 32'd1);
        chk("empty_pop_hold", 32'(dataOut), 32'd7);
        idle_clear();

        // Full FIFO, simultaneous push and pop with pointer wrap
        push(8'd10); push(8'd11); push(8'd12); push(8'd13);
        exp_list = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd14};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b1, 8'd14, 1'b0);
            chk("rw_full_dout", 32'(dataOut), 32'(exp_list[i]));
            chk("rw_full_cnt",  32'(count), 32'd4);
        end
        chk("rw_full_noovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) pop();

        // Empty FIFO, simultaneous push and pop: no fall-through
        step(1'b1, 1'b1, 1'b1, 8'd5, 1'b0);
        chk("rw_empty_cnt",  32'(count), 32'd1);
        chk("rw_empty_dout", 32'(dataOut), 32'd14);
        chk("rw_empty_unf",  32'(underflow), 32'd1);
        pop();
        chk("rw_empty_next", 32'(dataOut), 32'd5);

        // clearErr beats a same-cycle overflow event
        idle_clear();
        push(8'd20); push(8'd21); push(8'd22); push(8'd23);
        push(8'd24);
        chk("ovf_set", 32'(overflow), 32'd1);
        step(1'b1, 1'b1, 1'b0, 8'd25, 1'b1);
        chk("ovf_clr_prio", 32'(overflow), 32'd0);

        // Reset mid-operation with write held
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        push(8'd30); push(8'd31); push(8'd32);
        step(1'b0, 1'b1, 1'b0, 8'd33, 1'b0);
        chk("mid_rst_cnt",  32'(count), 32'd0);
        chk("mid_rst_dout", 32'(dataOut), 32'd0);
        pop();
        chk("mid_rst_unf",  32'(underflow), 32'd1);
        chk("mid_rst_hold", 32'(dataOut), 32'd0);

        // Short random run against the reference
        for (int i = 0; i < 60; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 1'($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Bound the run in case the main sequence stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, limit %0d ns reached", 200000);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, WIDTH >= 1.
REQ-002 Parameter DEPTH, default 4: number of storage entries, a power of two >= 2.
REQ-003 Parameter AF_LEVEL, default DEPTH-1: occupancy at or above which almostFull asserts, 1..DEPTH.
REQ-004 Parameter AE_LEVEL, default 1: occupancy at or below which almostEmpty asserts, 0..DEPTH-1.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 resetN  input  1  reset, synchronous, active-low.
REQ-007 write  input  1  push request for the current cycle.
REQ-008 read  input  1  pop request for the current cycle.
REQ-009 dataIn  input  WIDTH  word to push.
REQ-010 clearErr  input  1  clears the sticky overflow and underflow flags.
REQ-011 dataOut  output  WIDTH  registered word from the most recent accepted pop.
REQ-012 count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
REQ-013 full  output  1  count == DEPTH.
REQ-014 empty  output  1  count == 0.
REQ-015 almostFull  output  1  count >= AF_LEVEL.
REQ-016 almostEmpty  output  1  count <= AE_LEVEL.
REQ-017 overflow  output  1  sticky flag: a push was rejected.
REQ-018 underflow  output  1  sticky flag: a pop was rejected.

Function
REQ-019 Storage SHALL be a DEPTH x WIDTH circular buffer with write and read pointers of $clog2(DEPTH) bits, each wrapping from DEPTH-1 to 0.
REQ-020 Push accepted = write && (!full || read); an accepted push SHALL store dataIn at wrPtr and advance wrPtr by 1.
REQ-021 Pop accepted = read && !empty; an accepted pop SHALL load dataOut with mem[rdPtr] at the same edge and advance rdPtr by 1 (dataOut valid the cycle after read is sampled).
REQ-022 dataOut SHALL hold its value in every cycle with no accepted pop.
REQ-023 count SHALL increment on push-only, decrement on pop-only, and hold when both or neither are accepted.
REQ-024 Full with write && read: both SHALL be accepted; dataOut takes the old head; count stays DEPTH.
REQ-025 Empty with write && read: the push SHALL be accepted, the pop rejected (no fall-through); count becomes 1; dataOut holds; underflow sets.
REQ-026 full, empty, almostFull and almostEmpty SHALL be combinational decodes of the registered count.
REQ-027 overflow SHALL set on any edge where write && full && !read.
REQ-028 underflow SHALL set on any edge where read && empty.
REQ-029 Both sticky flags SHALL remain set until clearErr or reset; clearErr SHALL take priority over a set event in the same cycle.
REQ-030 A rejected push or pop SHALL leave the pointers, count, memory and dataOut unchanged.

Reset
REQ-031 With resetN low at a rising edge: wrPtr = 0, rdPtr = 0, count = 0, dataOut = 0, overflow = 0, underflow = 0; outputs then read empty = 1, full = 0, almostEmpty = 1, almostFull = 0 (when AF_LEVEL >= 1).
REQ-032 Reset SHALL override write, read and clearErr in the same cycle; memory contents need not be cleared.
REQ-033 Reset asserted mid-operation SHALL discard all stored words; the first pop after reset is rejected until a push occurs.

Verification (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-034 Reset, push 1, 3, 2 on consecutive cycles -> count 1, 2, 3; almostEmpty deasserts at count 2; almostFull asserts at count 3; empty = 0.
REQ-035 Continue: push 7, then push 9 while full -> count 4, full = 1, overflow = 1, 9 not stored; pops return 1, 3, 2, 7, then empty = 1.
REQ-036 Fill with 10, 11, 12, 13; assert write (dataIn 14) and read together for 6 cycles -> count stays 4; dataOut 10, 11, 12, 13, 14, 14; pointers wrap; no overflow.
REQ-037 From empty, write (dataIn 5) and read together -> count 1, dataOut unchanged, underflow = 1; the next read alone returns 5.
REQ-038 Set overflow, then assert clearErr in the same cycle as another overflow event -> overflow = 0 on the next cycle.
REQ-039 Push 3 words, pull resetN low for one edge while write = 1 -> count 0, empty = 1, dataOut = 0, flags 0; a subsequent read sets underflow.
